// File: rtl/adder_tb_pkg.sv
// Shared types, constants and helpers for the adder stimulus generator.
package adder_tb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int unsigned MODE_EXH  = 0;
  localparam int unsigned MODE_RAND = 1;

  // Number of vectors in one run for the given configuration.
  function automatic logic [31:0] vec_total(int unsigned n, int unsigned mode,
                                            logic [31:0] num_rand);
    if (mode == MODE_EXH) return 32'd1 << (2 * n + 1);
    return num_rand;
  endfunction

  // One Galois right-shift step of the 32-bit LFSR.
  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/adder_stim_gen_if.sv
// Vector stream handshake: {cin,a,b} qualified by valid, accepted by ready.
interface adder_stim_gen_if #(
  parameter int unsigned n = 2
) ();
  logic         valid;
  logic         ready;
  logic         cin;
  logic [n-1:0] a;
  logic [n-1:0] b;

  modport master (output valid, cin, a, b, input ready);
  modport slave  (input valid, cin, a, b, output ready);
endinterface

// File: rtl/adder_lfsr32.sv
// 32-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module adder_lfsr32
  import adder_tb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);
  logic [31:0] seed_fix;

  assign seed_fix = (seed == 32'd0) ? 32'd1 : seed;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= seed_fix;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end
endmodule

// File: rtl/adder_stim_gen.sv
// Stimulus source for adder DUVs: exhaustive or LFSR vectors over valid/ready.
module adder_stim_gen
  import adder_tb_pkg::*;
#(
  parameter int unsigned n        = 2,
  parameter int unsigned MODE     = 0,
  parameter logic [31:0] NUM_RAND = 32'd96,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  adder_stim_gen_if.master         stim,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              count
);
  localparam int unsigned W     = 2 * n + 1;
  localparam logic [31:0] TOTAL = vec_total(n, MODE, NUM_RAND);

  state_e      state_q;
  logic        valid_q;
  logic [W-1:0] vec_q;
  logic [31:0] lfsr_state;
  logic [31:0] lfsr_next;
  logic [W-1:0] first_vec;
  logic [W-1:0] next_vec;
  logic        xfer;
  logic        unused_lfsr;

  assign xfer      = (state_q == RUN) && stim.ready;
  assign lfsr_next = lfsr_step(lfsr_state);
  assign first_vec = (MODE == MODE_RAND) ? lfsr_state[W-1:0] : '0;
  assign next_vec  = (MODE == MODE_RAND) ? lfsr_next[W-1:0]
                                         : vec_q + {{(W-1){1'b0}}, 1'b1};
  assign unused_lfsr = ^{lfsr_state[31:W], lfsr_next[31:W]};

  // Reseeding happens only through rst; a restart continues the sequence.
  adder_lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .step  (xfer),
    .seed  (SEED),
    .state (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      vec_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            valid_q <= 1'b1;
            vec_q   <= first_vec;
            busy    <= 1'b1;
            done    <= 1'b0;
            count   <= '0;
          end
        end
        RUN: begin
          if (stim.ready) begin
            count <= (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
            // Final vector stays on the outputs while DONE.
            if (count == TOTAL - 32'd1) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              vec_q <= next_vec;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim.valid = valid_q;
  assign stim.cin   = vec_q[W-1];
  assign stim.a     = vec_q[W-2:n];
  assign stim.b     = vec_q[n-1:0];
endmodule

// File: tb/tb_adder_stim_gen.sv
// Bench: three generators (sweep, LFSR seed 1, LFSR seed 0) against a spec-level model.
module tb_adder_stim_gen;
  import adder_tb_pkg::*;

  localparam int unsigned N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st [3];
  logic        rd [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [31:0] cnt0, cnt1, cnt2;

  int n_pass  = 0;
  int n_total = 0;

  adder_stim_gen_if #(.n(N)) if0 ();
  adder_stim_gen_if #(.n(N)) if1 ();
  adder_stim_gen_if #(.n(N)) if2 ();

  assign if0.ready = rd[0];
  assign if1.ready = rd[1];
  assign if2.ready = rd[2];

  adder_stim_gen #(.n(N), .MODE(0)) u_exh (
    .clk(clk), .rst(rst), .start(st[0]), .stim(if0),
    .busy(busy_v[0]), .done(done_v[0]), .count(cnt0)
  );
  adder_stim_gen #(.n(N), .MODE(1), .NUM_RAND(32'd4), .SEED(32'd1)) u_rnd1 (
    .clk(clk), .rst(rst), .start(st[1]), .stim(if1),
    .busy(busy_v[1]), .done(done_v[1]), .count(cnt1)
  );
  adder_stim_gen #(.n(N), .MODE(1), .NUM_RAND(32'd4), .SEED(32'd0)) u_rnd0 (
    .clk(clk), .rst(rst), .start(st[2]), .stim(if2),
    .busy(busy_v[2]), .done(done_v[2]), .count(cnt2)
  );

  function automatic logic [4:0] vec_of(int d);
    case (d)
      0:       return {if0.cin, if0.a, if0.b};
      1:       return {if1.cin, if1.a, if1.b};
      default: return {if2.cin, if2.a, if2.b};
    endcase
  endfunction

  function automatic logic val_of(int d);
    case (d)
      0:       return if0.valid;
      1:       return if1.valid;
      default: return if2.valid;
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(int d);
    case (d)
      0:       return cnt0;
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Vector k steps into the LFSR stream from a given seed.
  function automatic logic [4:0] rv(logic [31:0] seed, int pos);
    logic [31:0] s;
    s = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < pos; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s[4:0];
  endfunction

  // Model: phase 0 idle, 1 run, 2 done; k accepted vectors; pos LFSR steps since reset.
  int          m_phase [3] = '{0, 0, 0};
  logic [31:0] m_k     [3] = '{0, 0, 0};
  int          m_pos   [3] = '{0, 0, 0};
  logic [4:0]  m_vec   [3] = '{0, 0, 0};
  int          m_mode  [3] = '{0, 1, 1};
  logic [31:0] m_seed  [3] = '{32'd1, 32'd1, 32'd0};
  logic [31:0] m_tot   [3] = '{32'd32, 32'd4, 32'd4};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_phase[d] = 0; m_k[d] = 0; m_pos[d] = 0; m_vec[d] = 5'd0;
      end else if (m_phase[d] != 1) begin
        if (st[d]) begin
          m_phase[d] = 1;
          m_k[d]     = 0;
          m_vec[d]   = (m_mode[d] == 1) ? rv(m_seed[d], m_pos[d]) : 5'd0;
        end
      end else if (rd[d]) begin
        m_k[d] = (m_k[d] == 32'hFFFF_FFFF) ? m_k[d] : m_k[d] + 32'd1;
        m_pos[d]++;
        if (m_k[d] == m_tot[d]) m_phase[d] = 2;
        else m_vec[d] = (m_mode[d] == 1) ? rv(m_seed[d], m_pos[d]) : m_k[d][4:0];
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_dut%0d", d),
          {24'd0, val_of(d), busy_v[d], done_v[d], cnt_of(d), vec_of(d)},
          {24'd0, m_phase[d] == 1, m_phase[d] == 1, m_phase[d] == 2, m_k[d], m_vec[d]});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    st  = '{1'b0, 1'b0, 1'b0};
    rd  = '{1'b1, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset_valid", val_of(0), 0);
    chk("reset_count", cnt_of(0), 0);
    chk("reset_vec",   vec_of(0), 0);
    chk("reset_done",  done_v[0], 0);
    rst = 1'b0;
    @(negedge clk);
    st = '{1'b1, 1'b1, 1'b1};

    // Full sweep and both random streams with ready held high.
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      if (j == 1) st = '{1'b0, 1'b0, 1'b0};
      if (j == 1)  chk("exh_first",   {val_of(0), vec_of(0)}, {1'b1, 5'b0_00_00});
      if (j == 6)  chk("exh_a1_b1",   vec_of(0), 5'b0_01_01);
      if (j == 17) chk("exh_cin1",    vec_of(0), 5'b1_00_00);
      if (j == 32) chk("exh_last",    vec_of(0), 5'b1_11_11);
      if (j == 33) chk("exh_done",    {val_of(0), done_v[0], cnt_of(0)}, {1'b0, 1'b1, 32'd32});
      if (j == 1)  chk("rnd_v1",      vec_of(1), 5'b0_00_01);
      if (j == 2)  chk("rnd_v2",      vec_of(1), 5'b0_00_11);
      if (j == 5)  chk("rnd_done",    {done_v[1], cnt_of(1)}, {1'b1, 32'd4});
      if (j == 1)  chk("seed0_v1",    vec_of(2), 5'b0_00_01);
      if (j == 3)  chk("seed0_v3",    vec_of(2), 5'b0_00_10);
    end

    // Restart from DONE with a 5-cycle stall and a stray start while running.
    st[0] = 1'b1;
    seen  = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (done_v[0]) begin
        seen = 1'b1;
        break;
      end
      st[0] = (j == 5);
      rd[0] = !(j >= 3 && j <= 7);
      if (j == 1) chk("restart_first", {cnt_of(0), vec_of(0)}, {32'd0, 5'd0});
      if (j >= 3 && j <= 7)
        chk("stall_hold", {val_of(0), cnt_of(0), vec_of(0)}, {1'b1, 32'd2, 5'b0_00_10});
      if (j == 9) chk("stall_resume", {cnt_of(0), vec_of(0)}, {32'd3, 5'd3});
    end
    chk("bp_done", {seen, cnt_of(0)}, {1'b1, 32'd32});
    rd[0] = 1'b1;

    // Reset in the middle of a run with ready toggling.
    st[0] = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      st[0] = 1'b0;
      if (cnt_of(0) == 32'd10) break;
      rd[0] = (j % 2 == 1);
    end
    chk("reach_10", cnt_of(0), 10);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    rd[0] = 1'b1;
    chk("midrun_reset", {val_of(0), busy_v[0], done_v[0], cnt_of(0)}, {3'b000, 32'd0});
    st = '{1'b1, 1'b1, 1'b1};
    @(negedge clk);
    st = '{1'b0, 1'b0, 1'b0};
    chk("post_rst_first", {val_of(0), cnt_of(0), vec_of(0)}, {1'b1, 32'd0, 5'd0});
    chk("post_rst_reseed", vec_of(1), 5'b0_00_01);
    repeat (5) @(negedge clk);
    chk("post_rst_rnd_done", {done_v[1], done_v[2]}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adder_stim_gen.md
Name: adder_stim_gen

Overview:
Synthesizable stimulus source for adder DUVs; it is the producing end of the vector stream that the adder check/log path consumes.
Emits {cin,a,b} vectors over a valid/ready handshake, in one of two modes: exhaustive sweep or 32-bit LFSR pseudo-random.
Sits in front of ref_adder and the DUV in self-checking benches and in FPGA bring-up.
Replaces file-based stimulus where file I/O is unavailable.

Parameters:
n, 2, operand width of a and b; legal range 1..15
MODE, 0, 0 = exhaustive sweep; 1 = LFSR random
NUM_RAND, 96, number of vectors emitted in MODE 1; legal range 1..2^32-1
SEED, 32'h0000_0001, LFSR initial state; a value of 0 is replaced by 1

Ports:
clk  in  1  clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begins a run when sampled high in IDLE or DONE
ready  in  1  consumer accepts the current vector
valid  out  1  cin/a/b hold a valid vector
cin  out  1  carry-in of the vector
a  out  n  operand a
b  out  n  operand b
busy  out  1  high in RUN
done  out  1  high in DONE; level signal
count  out  32  number of vectors accepted in the current or last run

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; valid=0, cin=0, a=0, b=0, busy=0, done=0, count=0; LFSR reloads SEED (0 becomes 1). Reset applies from any state, including mid-run and mid-stall.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN on the next cycle; the first vector appears with valid=1 in the first RUN cycle (1-cycle latency from start).
- RUN:
  - valid=1 continuously.
  - Transfer occurs on a cycle with valid=1 and ready=1; on a transfer, count increments and the next vector loads.
  - While ready=0, cin/a/b/count hold stable.
  - start is ignored in RUN.
- Vector order, MODE 0:
  - idx runs from 0 to 2^(2n+1)-1; {cin,a,b} = idx, with cin as MSB and b as LSBs.
  - Total vectors = 2^(2n+1); n=2 gives 32.
- Vector order, MODE 1:
  - {cin,a,b} = lfsr[2n:0].
  - The first vector comes from the loaded state, before any step.
  - The LFSR steps once per transfer: Galois right shift, polynomial mask 32'h8020_0003. If lsb=1, next = (s>>1) ^ mask; otherwise next = s>>1.
  - Total vectors = NUM_RAND.
- Last vector: the transfer of the final vector moves the FSM to DONE. On the following cycle valid=0, busy=0, done=1, and count equals the total.
- DONE:
  - Outputs hold, except that valid=0.
  - start=1 -> RUN; count clears to 0 and the first vector reloads.
  - MODE 0 restarts at idx 0. MODE 1 continues from the current LFSR state and does not reseed; only rst reseeds.
- Simultaneous rst and start: rst wins.
- A start pulse that coincides with the DONE transition is ignored; start is sampled only in IDLE/DONE.
- ready in IDLE/DONE is ignored.
- count saturates at 32'hFFFF_FFFF and never wraps.

Decomposition:
- Package adder_tb_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LFSR_MASK = 32'h8020_0003;
  - MODE_EXH = 0 and MODE_RAND = 1;
  - function vec_total(n, mode, num_rand).
- One sub-module: adder_lfsr32, with ports clk, rst, load, step, seed[31:0] and state[31:0]; it applies the seed-0-to-1 substitution internally.
- Exhaustive counter and FSM stay in adder_stim_gen.

Test Plan:
- Exhaustive sweep, n=2, MODE 0, ready=1 throughout, start pulse:
  - first vector cin=0 a=0 b=0;
  - 6th vector a=1 b=1;
  - 17th vector cin=1 a=0 b=0;
  - 32nd vector cin=1 a=3 b=3;
  - done=1 and count=32 one cycle after the 32nd transfer.
- Backpressure, MODE 0: ready=0 for cycles 3-7 of RUN -> vector idx 2 (cin=0 a=0 b=2) stays stable with valid=1 and count=2 throughout; sweep resumes at idx 3 once ready=1.
- Random mode, MODE 1, SEED=1, NUM_RAND=4:
  - vector 1: b=1, a=0, cin=0;
  - vector 2 (state 32'h8020_0003): b=3, a=0, cin=0;
  - done after 4 transfers with count=4.
- Reset mid-run: assert rst after 10 transfers with ready toggling -> next cycle valid=0, count=0, state IDLE; a new start then restarts at idx 0.
- Restart from DONE, MODE 0: start in DONE -> count clears, first vector is idx 0; start asserted while in RUN has no effect on order or count.
- Zero seed, MODE 1, SEED=0: first vector is b=1 (seed substituted); the stream matches the SEED=1 run exactly.
